sys_bus_ctrl: RTL

Parametrised system bus controller for the 65C02 core. Decodes the CPU address into `NUM_WIN` programmable windows for RAM, ROM, image/QOI buffers and the `qoi` accelerator, and drives one-hot chip selects and a registered read-data return. Inserts per-window wait states on `rdy_o`, and raises a sticky halt flag when the CPU parks on the all-ones address. It replaces fixed hard-coded address decode with one synthesizable block that the top level instantiates between `cpu_65c02` and the memories and peripherals.

---
 rtl/sys_bus_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: decodes the 65C02 address into NUM_WIN windows (one-hot cs, offset, registered read return, sticky halt on all-ones parking).
// Latency: cs_o/addr_o/we_o are combinational; rdata_o updates on the edge that ends the completion cycle.
// Backpressure: with SYS_BUS_WAIT_EN defined, rdy_o is held low for win_wait[sel] cycles per access; without it, rdy_o is tied high.
module sys_bus_ctrl #(
    parameter int                NUM_WIN  = 4,
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                WAIT_W   = 4,
    parameter logic [DATA_W-1:0] OPEN_BUS = 8'hEA,
    parameter int                HALT_CYC = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         ab,
    input  logic                      we,
    input  logic [DATA_W-1:0]         wdata_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      rdy_o,
    input  logic [NUM_WIN*ADDR_W-1:0] win_base,
    input  logic [NUM_WIN*ADDR_W-1:0] win_limit,
    input  logic [NUM_WIN*WAIT_W-1:0] win_wait,
    output logic [NUM_WIN-1:0]        cs_o,
    output logic                      we_o,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         wdata_o,
    input  logic [NUM_WIN*DATA_W-1:0] rdata_i,
    output logic                      halt_o
);
    localparam int HC_W = (HALT_CYC > 2) ? $clog2(HALT_CYC) : 1;
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(HALT_CYC - 1);

    logic              hit;
    logic              stall;
    logic [ADDR_W-1:0] sel_base;
    logic [DATA_W-1:0] sel_rdata;
    logic [WAIT_W-1:0] sel_wait;
    logic [HC_W-1:0]   hcnt;

    // Scan from the top index down so the lowest-index overlapping window wins.
    always_comb begin
        hit       = 1'b0;
        cs_o      = '0;
        sel_base  = '0;
        sel_rdata = '0;
        sel_wait  = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((win_base[i*ADDR_W +: ADDR_W] <= ab) && (ab <= win_limit[i*ADDR_W +: ADDR_W])) begin
                hit       = 1'b1;
                cs_o      = '0;
                cs_o[i]   = 1'b1;
                sel_base  = win_base[i*ADDR_W +: ADDR_W];
                sel_rdata = rdata_i[i*DATA_W +: DATA_W];
                sel_wait  = win_wait[i*WAIT_W +: WAIT_W];
            end
        end
    end

    assign addr_o  = hit ? (ab - sel_base) : '0;
    assign wdata_o = wdata_i;
    assign rdy_o   = ~stall;
    assign we_o    = we & hit & ~stall;

`ifdef SYS_BUS_WAIT_EN
    logic [WAIT_W-1:0] cnt;
    logic [ADDR_W-1:0] cap_ab;

    assign stall = hit && (cnt != sel_wait);

    // A new address while stalled restarts at 1 because this cycle already counts as its first wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            cap_ab <= '0;
        end else if (stall && (ab == cap_ab)) begin
            cnt    <= cnt + 1'b1;
        end else if (stall) begin
            cnt    <= {{(WAIT_W-1){1'b0}}, 1'b1};
            cap_ab <= ab;
        end else begin
            cnt    <= '0;
            cap_ab <= ab;
        end
    end
`else
    logic unused_wait;

    assign stall       = 1'b0;
    assign unused_wait = ^sel_wait;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o <= OPEN_BUS;
        end else if (!stall && !we) begin
            rdata_o <= hit ? sel_rdata : OPEN_BUS;
        end
    end

    // hcnt saturates one short of HALT_CYC; the next all-ones edge sets the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            halt_o <= 1'b0;
        end else if (ab == '1) begin
            if (hcnt == HC_MAX) begin
                halt_o <= 1'b1;
            end else begin
                hcnt   <= hcnt + 1'b1;
            end
        end else begin
            hcnt   <= '0;
        end
    end
endmodule
